// File: rtl/dom_share_encoder_d2.sv
// Boolean three-share encoder feeding a d=2 DOM AND gate: masks each accepted word with
// fresh LFSR bits and supplies the gate's per-cycle randomness p_rand_0..2.
module dom_share_encoder_d2 #(
  parameter int WIDTH = 1
) (
  input  logic             clock_0,
  input  logic             reset_0,
  input  logic             io_seed_load,
  input  logic [31:0]      io_seed,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_in_data,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_o0_s0,
  output logic [WIDTH-1:0] io_o0_s1,
  output logic [WIDTH-1:0] io_o0_s2,
  output logic             p_rand_0,
  output logic             p_rand_1,
  output logic             p_rand_2,
  output logic             io_rand_valid
);

  localparam int          STEP = 2 * WIDTH + 3;
  localparam logic [31:0] TAPS = 32'h8020_0003;

  typedef enum logic {
    ST_UNSEEDED = 1'b0,
    ST_RUN      = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      lfsr_q, lfsr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] s0_q, s0_d;
  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s2_q, s2_d;
  logic [2:0]       prand_q, prand_d;
  logic             rand_valid_q, rand_valid_d;

  logic [31:0]      chain_w [STEP+1];
  logic [STEP-1:0]  bits_w;
  logic [WIDTH-1:0] r1_w, r2_w;
  logic             run_w, seed_ok_w, accept_w;

  // Unrolled Galois stepping: stage gi emits its LSB, then shifts and folds in the taps.
  assign chain_w[0] = lfsr_q;
  for (genvar gi = 0; gi < STEP; gi++) begin : g_step
    assign bits_w[gi]      = chain_w[gi][0];
    assign chain_w[gi + 1] = {1'b0, chain_w[gi][31:1]} ^ (chain_w[gi][0] ? TAPS : 32'd0);
  end

  assign r1_w = bits_w[3 +: WIDTH];
  assign r2_w = bits_w[3 + WIDTH +: WIDTH];

  assign run_w     = (state_q == ST_RUN);
  assign seed_ok_w = io_seed_load && (io_seed != 32'd0);

  assign io_in_ready = run_w && (!out_valid_q || io_out_ready);
  assign accept_w    = io_in_valid && io_in_ready;

  always_comb begin
    state_d      = state_q;
    lfsr_d       = lfsr_q;
    out_valid_d  = out_valid_q;
    s0_d         = s0_q;
    s1_d         = s1_q;
    s2_d         = s2_q;
    prand_d      = prand_q;
    rand_valid_d = run_w;

    if (run_w) begin
      lfsr_d  = chain_w[STEP];
      prand_d = bits_w[2:0];
    end
    // A fresh seed overrides the advanced state; this cycle's bits still come from the old one.
    if (seed_ok_w) begin
      lfsr_d  = io_seed;
      state_d = ST_RUN;
    end

    if (accept_w) begin
      out_valid_d = 1'b1;
      s0_d        = io_in_data ^ r1_w ^ r2_w;
      s1_d        = r1_w;
      s2_d        = r2_w;
    end else if (io_out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock_0 or negedge reset_0) begin
    if (!reset_0) begin
      state_q      <= ST_UNSEEDED;
      lfsr_q       <= 32'd0;
      out_valid_q  <= 1'b0;
      s0_q         <= '0;
      s1_q         <= '0;
      s2_q         <= '0;
      prand_q      <= 3'd0;
      rand_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      out_valid_q  <= out_valid_d;
      s0_q         <= s0_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      prand_q      <= prand_d;
      rand_valid_q <= rand_valid_d;
    end
  end

  assign io_out_valid  = out_valid_q;
  assign io_o0_s0      = s0_q;
  assign io_o0_s1      = s1_q;
  assign io_o0_s2      = s2_q;
  assign p_rand_0      = prand_q[0];
  assign p_rand_1      = prand_q[1];
  assign p_rand_2      = prand_q[2];
  assign io_rand_valid = rand_valid_q;

endmodule

// File: doc/dom_share_encoder_d2.md
# dom_share_encoder_d2

Input-side counterpart of the d=2 (three-share) DOM masked AND gate. It converts unshared data words into three Boolean shares and supplies the fresh randomness (`p_rand_0..2`) that the downstream gate consumes each cycle. Masks and randomness come from an internal, reseedable 32-bit Galois LFSR. The block sits between the unmasked input boundary and the first masked gadget layer.

## Interface
- `WIDTH`, default 1: bits per data word; legal range 1..8.
- `clock_0`  in  1  clock; all state updates on the rising edge.
- `reset_0`  in  1  asynchronous, active-low reset.
- `io_seed_load`  in  1  load the seed this cycle.
- `io_seed`  in  32  LFSR seed; all-zero is illegal.
- `io_in_valid`  in  1  input word valid.
- `io_in_ready`  out  1  encoder can accept a word.
- `io_in_data`  in  WIDTH  unshared data word.
- `io_out_valid`  out  1  share registers hold a valid encoding.
- `io_out_ready`  in  1  downstream accepts the shares.
- `io_o0_s0`, `io_o0_s1`, `io_o0_s2`  out  WIDTH  shares of the data word.
- `p_rand_0`, `p_rand_1`, `p_rand_2`  out  1  fresh gate randomness, registered.
- `io_rand_valid`  out  1  `p_rand_*` are fresh this cycle.

## Operation
- **States:** UNSEEDED (entered on reset) and RUN.
  - UNSEEDED → RUN when `io_seed_load=1` and `io_seed≠0`.
  - A zero seed is ignored and the state is unchanged. This applies in RUN too.
- **LFSR:** 32 bits, taps 0x80200003 (x^32+x^22+x^2+x+1). One step is:
  - b = state[0]
  - state = state >> 1
  - if b, state ^= 0x80200003
  - The emitted bit is b.
- **Stepping:** in RUN the LFSR advances STEP = 2·WIDTH+3 steps every cycle (unrolled combinationally), emitting bits b0..b(STEP-1) in step order. In UNSEEDED the LFSR holds.
- **Bit allocation per cycle:**
  - b0, b1, b2 → `p_rand_0..2`, registered.
  - b[3+i] → r1[i].
  - b[3+WIDTH+i] → r2[i].
- **Encoding on accept** (`io_in_valid & io_in_ready`):
  - s1 = r1
  - s2 = r2
  - s0 = data ^ r1 ^ r2
  - All three are registered into the `io_o0_*` outputs.
  - r1/r2 from cycles without an accept are discarded.
- **Handshake:**
  - `io_in_ready` = RUN & (!`io_out_valid` | `io_out_ready`). This is a single-stage buffer with full throughput.
  - `io_out_valid` sets on accept.
  - It clears on `io_out_ready` when no new accept happens in the same cycle.
  - Shares hold stable while `io_out_valid & !io_out_ready`.
- **Seed load in RUN:** the new seed replaces the next state instead of the advanced state. The current cycle's bits (from the old state) are still used and emitted.
- **Unshared data:** the unshared value is never registered. Only s0 carries data, and only masked.

## Timing
- **Reset (async assert):**
  - All outputs are 0: `io_in_ready`, `io_out_valid`, shares, `p_rand_*`, `io_rand_valid`.
  - LFSR = 0, state = UNSEEDED.
  - Pending output is lost; the block must be reseeded.
- **Seed accepted at edge k:**
  - RUN from k.
  - `io_in_ready` can be 1 in cycle k+1.
  - First `p_rand_*` bits (from the seed state) and `io_rand_valid=1` appear after edge k+1.
- **Input latency:** word accepted at edge k → shares valid after edge k, i.e. 1 cycle latency.
- **Throughput:** one word per cycle when `io_out_ready` is held high.
- **Randomness:** `io_rand_valid` stays 1 every cycle in RUN, with fresh bits every cycle, independent of the data handshake.
- **Back-to-back seed loads:** the last one wins.

## Test plan
- Reset, then `io_in_valid=1` with no seed → `io_in_ready=0`, `io_out_valid=0`, `io_rand_valid=0` for 20 cycles; `io_seed_load` with seed 0x00000000 → still UNSEEDED.
- WIDTH=1, seed 0x00000001, 64 random words back-to-back with `io_out_ready=1` → one output per cycle, 1 cycle latency. For each output:
  - s0^s1^s2 equals the input bit.
  - s1, s2, `p_rand_*` match a bit-exact software LFSR model (first step emits b0=1 and state becomes 0x80200003).
- WIDTH=8, `io_out_ready` toggled pseudo-randomly over 500 words → no loss or duplication, shares stable while stalled, XOR recombination equals the input every word.
- Reseed with 0xDEADBEEF while `io_in_valid=1` in RUN → that word is encoded with the old-state bits; the following cycle's bits match a model restarted from 0xDEADBEEF.
- Assert `reset_0=0` mid-stream with `io_out_valid=1` → all outputs 0 immediately (asynchronous), UNSEEDED after release, LFSR output unchanged until reseed.
- Seed 0x00000001 twice from reset, same data, WIDTH=1 → identical share and `p_rand_*` sequences (determinism); over 10k cycles each of s1, s2 and `p_rand_*` has ones-density within 0.48–0.52.
